conv_window_gen: RTL
====================

# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the MAC array in the convolution kernel. It accepts one raster-ordered 8-bit feature-map channel over a valid/ready stream and buffers two lines internally. It emits one zero-padded 3x3 window per output pixel, packed into the 128-bit `din` format the MACs consume, with a single-cycle valid that drives the MAC `vld_i`.

## Interface
- `IFM_WIDTH`, 256: pixels per row, ≥2.
- `IFM_HEIGHT`, 256: rows per frame, ≥2.
- `DW`, 8: pixel width in bits; window bytes are DW wide.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  frame start pulse; honoured only in IDLE.
- `pix_i`  in  DW  input pixel, raster order.
- `pix_vld_i`  in  1  input pixel valid.
- `pix_rdy_o`  out  1  input ready; a pixel is accepted when `pix_vld_i && pix_rdy_o`.
- `win_o`  out  128  packed window; byte k sits at [8k+7:8k] for k = 3*dy + dx, where dy=0 is the top row and dx=0 is the left column. Bits [127:72] are always 0.
- `win_vld_o`  out  1  window valid, one cycle per window; maps to MAC `vld_i`.
- `frame_done_o`  out  1  one-cycle pulse with the last window of a frame.

## Operation
- FSM states:
  - IDLE: `start_i` moves to RUN and clears y, x.
  - RUN: steps through the virtual grid.
  - DONE: raises `frame_done_o`, then returns to IDLE.
- Virtual scan grid is (IFM_HEIGHT+1) x (IFM_WIDTH+1), with y in 0..H and x in 0..W, raster order.
  - Real position (y<H and x<W): the step occurs only when a pixel is accepted. `pix_rdy_o` = (state==RUN) && real position.
  - Padding position (y==H or x==W): the step occurs unconditionally, 1 per cycle, with injected value 0. `pix_rdy_o`=0.
- Two line buffers, depth W+1, indexed by x:
  - lb0 holds row y-1; lb1 holds row y-2.
  - On each step: lb1[x]←lb0[x], lb0[x]←new.
- 3x3 shift registers take column {lb1[x], lb0[x], new} (top to bottom) on each step. The window is then centred on (r,c) = (y-1, x-1).
- Output is generated on steps with y≥1 and x≥1. This gives exactly H*W windows in raster order of centre.
- Zero masking is computed from (r,c), not from buffer contents:
  - top row zeroed if r==0;
  - bottom row zeroed if r==H-1;
  - left column zeroed if c==0;
  - right column zeroed if c==W-1.
- Line buffer contents are never cleared. Masking makes stale data irrelevant.
- Last step (y==H, x==W) moves to DONE.
- `start_i` while in RUN or DONE is ignored.

## Timing
- Reset values: `pix_rdy_o`=0, `win_o`=0, `win_vld_o`=0, `frame_done_o`=0; state=IDLE; counters=0.
- Reset mid-frame aborts immediately. The next frame requires a new `start_i`.
- `pix_rdy_o` is high in the first cycle after the edge that samples `start_i`.
- Latency: the edge that performs step (r+1, c+1) updates the shift registers. The following edge registers `win_o`/`win_vld_o`. The window is therefore visible 2 cycles after the step edge.
- `win_o` holds its value when `win_vld_o`=0.
- `frame_done_o` is asserted in the same cycle as the final `win_vld_o` (centre H-1, W-1).
- Input stalls (`pix_vld_i`=0 at a real position) produce bubbles on `win_vld_o` and no other effect.
- No output backpressure: the consumer must accept every window.
- Minimum frame time, with no stalls: (H+1)(W+1) + 3 cycles from `start_i`.

## Structure
- Shared package/defines: window packing byte index (k = 3*dy + dx), `WIN_BYTES`=9, `DIN_WIDTH`=128, FSM state encoding. These constants are reused by the MAC and the bench.
- One sub-module, `line_buffer`: depth W+1, DW wide, write and read at the same index in one cycle. It is instantiated twice, or once at 2*DW width.
- Top-level holds the FSM, the y/x counters, the shift registers and masking, and the output register.

## Test plan
- 4x4 frame with pixel = 4r+c+1, no stalls:
  - centre (0,0) → bytes 0,0,0, 0,1,2, 0,5,6;
  - centre (1,1) → 1,2,3, 5,6,7, 9,10,11;
  - centre (3,3) → 11,12,0, 15,16,0, 0,0,0;
  - 16 windows total, with `frame_done_o` on the 16th.
- Same 4x4 frame with `pix_vld_i` randomly deasserted about 50% of cycles → identical window sequence; `pix_rdy_o` low on all padding steps.
- `start_i` pulsed again mid-frame → ignored; still exactly 16 windows.
- `rstn` asserted after 7 pixels → all outputs 0 immediately. A new `start_i` plus a full 4x4 frame → correct 16 windows with no stale data leaking through the masking.
- 256x256 frame with pixel = (r*7+c*3) mod 256, compared against a golden padded-window model → 65536 matching windows, and `frame_done_o` 257*257+3 cycles after `start_i`.
- Bits [127:72] checked = 0 on every valid window across all scenarios.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the 3x3 window stream: window packing, MAC din width, FSM encoding.
package conv_window_gen_pkg;

  localparam int WIN_BYTES = 9;
  localparam int DIN_WIDTH = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Which window edges are forced to zero for the current centre.
  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } win_mask_t;

  // Byte slot of window element (dy, dx); dy=0 is the top row, dx=0 the left column.
  function automatic int win_byte(input int dy, input int dx);
    return 3 * dy + dx;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Simple dual-port line memory with registered read, suitable for block RAM inference.
module line_buffer #(
  parameter int DEPTH = 257,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 zero-padded window generator: scans an (H+1)x(W+1) virtual grid,
// keeps two lines in one 2*DW wide line buffer and emits one packed window per pixel.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IFM_WIDTH  = 256,
  parameter int IFM_HEIGHT = 256,
  parameter int DW         = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [DW-1:0]        pix_i,
  input  logic                 pix_vld_i,
  output logic                 pix_rdy_o,
  output logic [DIN_WIDTH-1:0] win_o,
  output logic                 win_vld_o,
  output logic                 frame_done_o
);

  localparam int XW = $clog2(IFM_WIDTH + 1);
  localparam int YW = $clog2(IFM_HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IFM_WIDTH);
  localparam logic [YW-1:0] Y_LAST = YW'(IFM_HEIGHT);

  logic [1:0]           state_reg;
  logic [XW-1:0]        x_reg, x_next;
  logic [YW-1:0]        y_reg, y_next;
  logic                 pad, step, last_step;
  logic [DW-1:0]        new_pix, lb0, lb1;
  logic [2*DW-1:0]      lb_rd_data;
  logic [XW-1:0]        lb_rd_addr;
  logic [DW-1:0]        win_reg [3][3];
  win_mask_t            mask_reg;
  logic                 pend_reg, pend_last_reg;
  logic [DIN_WIDTH-1:0] win_masked, win_out_reg;
  logic                 win_vld_reg, frame_done_reg;

  always_comb begin
    pad       = (y_reg == Y_LAST) || (x_reg == X_LAST);
    step      = (state_reg == ST_RUN) && (pad || pix_vld_i);
    last_step = step && (y_reg == Y_LAST) && (x_reg == X_LAST);
    new_pix   = pad ? '0 : pix_i;
    x_next    = x_reg + XW'(1);
    y_next    = y_reg;
    if (x_reg == X_LAST) begin
      x_next = '0;
      y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
    end
    // Read one slot ahead so the registered read lands on the next position.
    lb_rd_addr = step ? x_next : x_reg;
  end

  assign pix_rdy_o = (state_reg == ST_RUN) && !pad;

  line_buffer #(
    .DEPTH(IFM_WIDTH + 1),
    .WIDTH(2 * DW)
  ) u_line_buffer (
    .clk    (clk),
    .we     (step),
    .wr_addr(x_reg),
    .wr_data({lb0, new_pix}),
    .rd_addr(lb_rd_addr),
    .rd_data(lb_rd_data)
  );

  assign lb1 = lb_rd_data[2*DW-1:DW];
  assign lb0 = lb_rd_data[DW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= ST_RUN;
            x_reg     <= '0;
            y_reg     <= '0;
          end
        end
        ST_RUN: begin
          if (step) begin
            x_reg <= x_next;
            y_reg <= y_next;
          end
          if (last_step) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // New column enters on the right: {row y-2, row y-1, row y} top to bottom.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          win_reg[dy][dx] <= '0;
        end
      end
    end else if (step) begin
      for (int dy = 0; dy < 3; dy++) begin
        win_reg[dy][0] <= win_reg[dy][1];
        win_reg[dy][1] <= win_reg[dy][2];
      end
      win_reg[0][2] <= lb1;
      win_reg[1][2] <= lb0;
      win_reg[2][2] <= new_pix;
    end
  end

  // Centre is (y-1, x-1); edge masks come from position, never from buffer contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      mask_reg      <= '0;
    end else begin
      pend_reg      <= step && (y_reg != '0) && (x_reg != '0);
      pend_last_reg <= last_step;
      if (step) begin
        mask_reg <= {y_reg == YW'(1), y_reg == Y_LAST, x_reg == XW'(1), x_reg == X_LAST};
      end
    end
  end

  for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_byte
    localparam int DY = gi / 3;
    localparam int DX = gi % 3;
    logic zero;
    assign zero = (DY == 0 && mask_reg.top) || (DY == 2 && mask_reg.bottom) ||
                  (DX == 0 && mask_reg.left) || (DX == 2 && mask_reg.right);
    assign win_masked[win_byte(DY, DX)*DW +: DW] = zero ? '0 : win_reg[DY][DX];
  end
  assign win_masked[DIN_WIDTH-1:WIN_BYTES*DW] = '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_out_reg    <= '0;
      win_vld_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      win_vld_reg    <= pend_reg;
      frame_done_reg <= pend_reg && pend_last_reg;
      if (pend_reg) begin
        win_out_reg <= win_masked;
      end
    end
  end

  assign win_o        = win_out_reg;
  assign win_vld_o    = win_vld_reg;
  assign frame_done_o = frame_done_reg;

endmodule
